// File: rtl/aes_key_expansion_writer.sv
// aes_key_expansion_writer: streams the 176-byte AES-128 key schedule, one byte per cycle, into a byte-wide memory.
// Revision: 1.0
`default_nettype none

module aes_key_expansion_writer (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] key_in,
  output logic [7:0]   wr_key,
  output logic [7:0]   wr_addr,
  output logic         wr_en,
  output logic         busy,
  output logic         done
);

  localparam logic [7:0] LAST_ADDR = 8'd175;

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t      state;
  logic [7:0]  hist [16];
  logic [7:0]  next_addr;
  logic [7:0]  rot_byte;
  logic [10:0] sbox_msb;
  logic [7:0]  sub_byte;
  logic [7:0]  rcon;
  logic [7:0]  next_byte;

  function automatic logic [7:0] rcon_of(input logic [3:0] round);
    case (round)
      4'd1:    rcon_of = 8'h01;
      4'd2:    rcon_of = 8'h02;
      4'd3:    rcon_of = 8'h04;
      4'd4:    rcon_of = 8'h08;
      4'd5:    rcon_of = 8'h10;
      4'd6:    rcon_of = 8'h20;
      4'd7:    rcon_of = 8'h40;
      4'd8:    rcon_of = 8'h80;
      4'd9:    rcon_of = 8'h1b;
      4'd10:   rcon_of = 8'h36;
      default: rcon_of = 8'h00;
    endcase
  endfunction

  // hist[15] is the byte just written, hist[0] the one 16 back; the key itself
  // sits in hist untouched until address 16 is produced.
  always_comb begin
    next_addr = wr_addr + 8'd1;
    rot_byte  = (next_addr[1:0] == 2'd3) ? hist[9] : hist[13];
    sbox_msb  = 11'd2047 - {rot_byte, 3'b000};
    sub_byte  = SBOX[sbox_msb -: 8];
    rcon      = (next_addr[1:0] == 2'd0) ? rcon_of(next_addr[7:4]) : 8'h00;
    if (next_addr < 8'd16)
      next_byte = hist[next_addr[3:0]];
    else if (next_addr[3:2] == 2'd0)
      next_byte = hist[0] ^ sub_byte ^ rcon;
    else
      next_byte = hist[0] ^ hist[12];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      wr_key  <= 8'h00;
      wr_addr <= 8'h00;
      wr_en   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      for (int k = 0; k < 16; k++) hist[k] <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          done    <= 1'b0;
          wr_addr <= 8'h00;
          if (start) begin
            state  <= RUN;
            wr_en  <= 1'b1;
            busy   <= 1'b1;
            wr_key <= key_in[127:120];
            for (int k = 0; k < 16; k++) hist[k] <= key_in[127 - 8*k -: 8];
          end else begin
            wr_en  <= 1'b0;
            busy   <= 1'b0;
            wr_key <= 8'h00;
          end
        end
        RUN: begin
          if (wr_addr == LAST_ADDR) begin
            state   <= IDLE;
            wr_en   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b1;
            wr_addr <= 8'h00;
            wr_key  <= 8'h00;
          end else begin
            done    <= 1'b0;
            wr_addr <= next_addr;
            wr_key  <= next_byte;
            if (next_addr >= 8'd16) begin
              for (int k = 0; k < 15; k++) hist[k] <= hist[k+1];
              hist[15] <= next_byte;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: doc/aes_key_expansion_writer.md
AES_KEY_EXPANSION_WRITER -- requirements
Module: aes_key_expansion_writer

Interface
REQ-001 The block SHALL have no parameters; AES-128 only (11 round keys, 176 bytes).
REQ-002 clk  input  1  single clock; all state on posedge clk.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 start  input  1  one-cycle request to expand key_in; honoured only when busy=0.
REQ-005 key_in  input  128  cipher key; key_in[127:120] is key byte 0.
REQ-006 wr_key  output  8  round-key byte to key-schedule memory write data.
REQ-007 wr_addr  output  8  byte address 0..175 in the key-schedule memory.
REQ-008 wr_en  output  1  write strobe; the byte is written on the same clock edge.
REQ-009 busy  output  1  high while expansion is in progress.
REQ-010 done  output  1  one-cycle pulse after the last byte is written.

Function
REQ-011 The block SHALL be a two-state FSM: IDLE, RUN.
REQ-012 IDLE -> RUN on the clk edge where start=1; key_in SHALL be captured on that edge only.
REQ-013 start while in RUN SHALL be ignored, with no restart and no re-capture.
REQ-014 In RUN, exactly one byte SHALL be emitted per cycle, with wr_en=1 for 176 consecutive cycles and no gaps.
REQ-015 wr_addr SHALL be 0 in the first RUN cycle and increment by 1 each cycle to 175.
REQ-016 The first write (addr 0) SHALL occur in the cycle immediately after the start edge.
REQ-017 Let b[i] be the byte at address i, j=i/4 and p=i%4.
REQ-018 For i<16, b[i] SHALL equal key byte i.
REQ-019 For i>=16 with j%4!=0, b[i] SHALL equal b[i-16] xor b[i-4].
REQ-020 For i>=16 with j%4==0, b[i] SHALL equal b[i-16] xor S(r) xor (p==0 ? RCON[j/4] : 0).
REQ-021 In REQ-020, r SHALL be b[i-3] for p=0..2 and b[i-7] for p=3 (RotWord).
REQ-022 S SHALL be the FIPS-197 forward S-box, one byte-wide combinational lookup inside the block.
REQ-023 RCON[1..10] SHALL be 01,02,04,08,10,20,40,80,1B,36.
REQ-024 History SHALL be held in a 16-byte shift register of the most recent bytes; no other storage of the expanded key is permitted.
REQ-025 wr_key and wr_addr SHALL be registered outputs; no combinational path from inputs to outputs.
REQ-026 busy SHALL be 1 in exactly the 176 cycles with wr_en=1.
REQ-027 After the addr-175 write the FSM SHALL return to IDLE, with done=1 for one cycle and busy=0 in that same cycle.
REQ-028 A start asserted in the done cycle SHALL be accepted, so back-to-back expansions are separated by exactly one idle cycle.
REQ-029 In IDLE, wr_en SHALL be 0, and wr_addr and wr_key SHALL hold 0.

Reset
REQ-030 rst_n=0 SHALL immediately force IDLE with wr_en=0, busy=0, done=0, wr_addr=0, wr_key=0, and clear the shift register.
REQ-031 Reset mid-RUN SHALL abort without further writes; memory content is then partial and undefined to consumers.
REQ-032 After rst_n deasserts, the first start SHALL behave as in REQ-012..016.

Verification
REQ-033 FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c -> addr 16..19 = a0 fa fe 17; addr 160..175 = d0 14 f9 a8 c9 ee 25 89 e1 3f 0c c8 b6 63 0c a6.
REQ-034 All-zero key -> addr 0..15 = 00; addr 16..31 = 62 63 63 63 repeated 4x; addr 32..35 = 9b 98 98 c9.
REQ-035 Timing check -> wr_en high exactly 176 cycles starting one cycle after start, addresses contiguous 0..175, done pulses once on the following cycle.
REQ-036 start pulsed at addr 50 with a different key -> ignored; output stream identical to the uninterrupted run.
REQ-037 rst_n low at addr 100 -> wr_en=0 immediately; a new start after release restarts at addr 0 with correct bytes.
REQ-038 start held high continuously -> a new expansion begins in each done cycle, with one non-writing cycle between runs.
